axi_lite_ipif_bridge: RTL and testbench

- AXI4-Lite slave that converts each software register access into a single IPIF transaction (Bus2IP_* / IP2Bus_*).
- Sits directly upstream of the IPIF register file in every core.
- Processes one transaction at a time.
- Arbitrates between pending reads and writes, holds chip-select until the IPIF acknowledges, then returns the AXI response.

---
 rtl/axi_lite_ipif_bridge.sv | 183 ++++++++++++++++++
 tb/tb_axi_lite_ipif_bridge.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ipif_bridge.sv
// AXI4-Lite slave that turns each register access into one IPIF cycle.
// Ports: S_AXI_* AXI4-Lite slave (AW/W/B/AR/R), Bus2IP_* request side,
//   IP2Bus_* completion side. Clock/reset forwarded as Bus2IP_Clk/Resetn.
// Option: define IPIF_BRIDGE_TIMEOUT_EN to bound the ack wait to
//   C_TIMEOUT_CYCLES cycles (SLVERR on expiry).
module axi_lite_ipif_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 64
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            Bus2IP_Clk,
  output logic                            Bus2IP_Resetn,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr,
  output logic                            Bus2IP_CS,
  output logic                            Bus2IP_RNW,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data,
  input  logic                            IP2Bus_RdAck,
  input  logic                            IP2Bus_WrAck,
  input  logic                            IP2Bus_Error
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  if (C_TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("C_TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP
  } state_t;

  state_t state_q, state_d;

  logic idle;
  logic take_wr, take_rd;
  logic wr_done, rd_done;
  logic tmo;
  logic last_rd_q;
  logic acc_wr_q, acc_rd_q;

  assign Bus2IP_Clk    = S_AXI_ACLK;
  assign Bus2IP_Resetn = S_AXI_ARESETN;

  assign idle = (state_q == IDLE);

  // Both pending: serve whichever type did not go last.
  assign take_wr = S_AXI_AWVALID && S_AXI_WVALID &&
                   (last_rd_q || !S_AXI_ARVALID);
  assign take_rd = S_AXI_ARVALID && !take_wr;

  assign Bus2IP_CS = (state_q == WR_REQ) ||
                     (state_q == RD_REQ);

  assign wr_done = (state_q == WR_REQ) &&
                   (IP2Bus_WrAck || tmo);
  assign rd_done = (state_q == RD_REQ) &&
                   (IP2Bus_RdAck || tmo);

`ifdef IPIF_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(C_TIMEOUT_CYCLES);

  logic [CW-1:0] tmo_q;

  // Zero on the first CS cycle, +1 per cycle CS is held.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tmo_q <= '0;
    end else if (Bus2IP_CS) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end

  assign tmo = Bus2IP_CS &&
               (tmo_q == CW'(C_TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_wr) begin
          state_d = WR_REQ;
        end else if (take_rd) begin
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        if (wr_done) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (S_AXI_BREADY) state_d = IDLE;
      end
      RD_REQ: begin
        if (rd_done) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (S_AXI_RREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      acc_wr_q    <= 1'b0;
      acc_rd_q    <= 1'b0;
      last_rd_q   <= 1'b1;
      Bus2IP_Addr <= '0;
      Bus2IP_Data <= '0;
      Bus2IP_BE   <= '0;
      Bus2IP_RNW  <= 1'b1;
      S_AXI_RDATA <= '0;
      S_AXI_BRESP <= OKAY;
      S_AXI_RRESP <= OKAY;
    end else begin
      acc_wr_q <= idle && take_wr;
      acc_rd_q <= idle && take_rd;
      if (idle && take_wr) begin
        Bus2IP_Addr <= S_AXI_AWADDR;
        Bus2IP_Data <= S_AXI_WDATA;
        Bus2IP_BE   <= S_AXI_WSTRB;
        Bus2IP_RNW  <= 1'b0;
        last_rd_q   <= 1'b0;
      end else if (idle && take_rd) begin
        Bus2IP_Addr <= S_AXI_ARADDR;
        Bus2IP_BE   <= '1;
        Bus2IP_RNW  <= 1'b1;
        last_rd_q   <= 1'b1;
      end
      // An ack in the expiry cycle still wins over the timeout.
      if (wr_done) begin
        S_AXI_BRESP <= (IP2Bus_WrAck && !IP2Bus_Error) ?
                       OKAY : SLVERR;
      end
      if (rd_done) begin
        S_AXI_RRESP <= (IP2Bus_RdAck && !IP2Bus_Error) ?
                       OKAY : SLVERR;
        S_AXI_RDATA <= IP2Bus_RdAck ? IP2Bus_Data : '0;
      end
    end
  end

  assign S_AXI_AWREADY = acc_wr_q;
  assign S_AXI_WREADY  = acc_wr_q;
  assign S_AXI_ARREADY = acc_rd_q;
  assign S_AXI_BVALID  = (state_q == WR_RESP);
  assign S_AXI_RVALID  = (state_q == RD_RESP);

endmodule

// File: tb/tb_axi_lite_ipif_bridge.sv
// Scoreboard bench for axi_lite_ipif_bridge: random AXI master,
// random IPIF responder, response monitor with backpressure.
module tb_axi_lite_ipif_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] S_AXI_AWADDR = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        Bus2IP_Clk;
  logic        Bus2IP_Resetn;
  logic [31:0] Bus2IP_Addr;
  logic        Bus2IP_CS;
  logic        Bus2IP_RNW;
  logic [31:0] Bus2IP_Data;
  logic [3:0]  Bus2IP_BE;
  logic [31:0] IP2Bus_Data;
  logic        IP2Bus_RdAck;
  logic        IP2Bus_WrAck;
  logic        IP2Bus_Error;

  logic        rd_ack_r;
  logic [31:0] rdata_r;
  logic        late_ack = 1'b0;

  assign IP2Bus_RdAck = rd_ack_r | late_ack;
  assign IP2Bus_Data  = late_ack ? 32'hFFFF_FFFF : rdata_r;

  always #5 clk = ~clk;

  axi_lite_ipif_bridge #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32),
    .C_TIMEOUT_CYCLES(8)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA),
    .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA),
    .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .Bus2IP_Clk(Bus2IP_Clk),
    .Bus2IP_Resetn(Bus2IP_Resetn),
    .Bus2IP_Addr(Bus2IP_Addr),
    .Bus2IP_CS(Bus2IP_CS),
    .Bus2IP_RNW(Bus2IP_RNW),
    .Bus2IP_Data(Bus2IP_Data),
    .Bus2IP_BE(Bus2IP_BE),
    .IP2Bus_Data(IP2Bus_Data),
    .IP2Bus_RdAck(IP2Bus_RdAck),
    .IP2Bus_WrAck(IP2Bus_WrAck),
    .IP2Bus_Error(IP2Bus_Error)
  );

  typedef struct {
    bit          rnw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ipreq_t;

  typedef struct {
    bit          rnw;
    logic [1:0]  resp;
    logic [31:0] data;
  } resp_t;

  ipreq_t ip_q[$];
  resp_t  rsp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int rsp_seen = 0;
  bit ip_silent = 1'b0;
  bit last_rd_m = 1'b1;

  bit          directed = 1'b0;
  int          f_dly = 0;
  bit          f_err = 1'b0;
  logic [31:0] f_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing at t=%0t", nm, $time);
  endtask

  function automatic ipreq_t mk(input bit rnw);
    ipreq_t t;
    t.rnw  = rnw;
    t.addr = $urandom & 32'hFFFF_FFFC;
    t.data = $urandom;
    t.be   = 4'($urandom_range(0, 15));
    return t;
  endfunction

  // IPIF register-file model: random ack delay, wrong-type acks,
  // random error and read data; records the AXI response it implies.
  initial begin : responder
    ipreq_t e;
    resp_t  r;
    int     dly;
    bit     keep;
    IP2Bus_WrAck = 1'b0;
    IP2Bus_Error = 1'b0;
    rd_ack_r = 1'b0;
    rdata_r  = '0;
    forever begin
      @(negedge clk);
      if (Bus2IP_CS && !ip_silent && rst_n) begin
        if (ip_q.size() == 0) begin
          fail("ip_unexpected_cs");
          e.rnw = Bus2IP_RNW;
        end else begin
          e = ip_q.pop_front();
          chk("ip_rnw", 32'(Bus2IP_RNW), 32'(e.rnw));
          chk("ip_addr", Bus2IP_Addr, e.addr);
          chk("ip_be", 32'(Bus2IP_BE), e.rnw ? 32'hF : 32'(e.be));
          if (!e.rnw) chk("ip_wdata", Bus2IP_Data, e.data);
          chk("accept_pulse", e.rnw ? 32'(S_AXI_ARREADY) :
              32'(S_AXI_AWREADY & S_AXI_WREADY), 32'd1);
        end
        dly = directed ? f_dly : $urandom_range(0, 3);
        repeat (dly) begin
          IP2Bus_WrAck = e.rnw && ($urandom_range(0, 1) == 1);
          rd_ack_r = !e.rnw && ($urandom_range(0, 1) == 1);
          @(negedge clk);
          chk("cs_hold", 32'(Bus2IP_CS), 32'd1);
        end
        IP2Bus_Error = directed ? f_err : ($urandom_range(0, 3) == 0);
        rdata_r = directed ? f_rdata : $urandom;
        IP2Bus_WrAck = !e.rnw;
        rd_ack_r = e.rnw;
        r.rnw  = e.rnw;
        r.resp = IP2Bus_Error ? 2'b10 : 2'b00;
        r.data = e.rnw ? rdata_r : 32'h0;
        rsp_q.push_back(r);
        keep = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        chk("cs_drop", 32'(Bus2IP_CS), 32'd0);
        chk("resp_valid", e.rnw ? 32'(S_AXI_RVALID) :
            32'(S_AXI_BVALID), 32'd1);
        if (keep) begin
          rdata_r = $urandom;
          IP2Bus_Error = !IP2Bus_Error;
          @(negedge clk);
        end
        IP2Bus_WrAck = 1'b0;
        rd_ack_r = 1'b0;
        IP2Bus_Error = 1'b0;
      end
    end
  end

  // Response monitor: drives B/R READY with random and long
  // backpressure, pops the scoreboard on every handshake.
  initial begin : monitor
    resp_t       x;
    int          hold;
    bit          rp, bp;
    logic [31:0] pr;
    logic [1:0]  prr, pbr;
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    hold = 0; rp = 0; bp = 0; pr = '0; prr = '0; pbr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        rp = 0; bp = 0; hold = 0;
      end else begin
        if (rp) begin
          chk("rvalid_stable", 32'(S_AXI_RVALID), 32'd1);
          chk("rdata_stable", S_AXI_RDATA, pr);
          chk("rresp_stable", 32'(S_AXI_RRESP), 32'(prr));
        end
        if (bp) begin
          chk("bvalid_stable", 32'(S_AXI_BVALID), 32'd1);
          chk("bresp_stable", 32'(S_AXI_BRESP), 32'(pbr));
        end
        if (S_AXI_RVALID || S_AXI_BVALID) begin
          chk("chan_quiet", 32'({S_AXI_AWREADY, S_AXI_WREADY,
              S_AXI_ARREADY, Bus2IP_CS}), 32'd0);
          if (hold == 0 && !rp && !bp && $urandom_range(0, 3) == 0)
            hold = 10;
        end
        if (hold > 0) begin
          hold--;
          S_AXI_BREADY = 1'b0;
          S_AXI_RREADY = 1'b0;
        end else begin
          S_AXI_BREADY = ($urandom_range(0, 2) != 0);
          S_AXI_RREADY = ($urandom_range(0, 2) != 0);
        end
        rp = 0;
        bp = 0;
        if (S_AXI_RVALID) begin
          if (S_AXI_RREADY) begin
            if (rsp_q.size() == 0) fail("r_unexpected");
            else begin
              x = rsp_q.pop_front();
              chk("r_type", 32'd1, 32'(x.rnw));
              chk("rresp", 32'(S_AXI_RRESP), 32'(x.resp));
              chk("rdata", S_AXI_RDATA, x.data);
            end
            rsp_seen++;
          end else begin
            rp = 1; pr = S_AXI_RDATA; prr = S_AXI_RRESP;
          end
        end
        if (S_AXI_BVALID) begin
          if (S_AXI_BREADY) begin
            if (rsp_q.size() == 0) fail("b_unexpected");
            else begin
              x = rsp_q.pop_front();
              chk("b_type", 32'd0, 32'(x.rnw));
              chk("bresp", 32'(S_AXI_BRESP), 32'(x.resp));
            end
            rsp_seen++;
          end else begin
            bp = 1; pbr = S_AXI_BRESP;
          end
        end
      end
    end
  end

  task automatic drive_w(input ipreq_t t, input int wdly,
                         input bit lat);
    int n;
    S_AXI_AWADDR  = t.addr;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA   = t.data;
    S_AXI_WSTRB   = t.be;
    repeat (wdly) begin
      @(negedge clk);
      chk("aw_only_wait", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'd0);
    end
    S_AXI_WVALID = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!S_AXI_AWREADY && n < 100);
    chk("aw_accept", 32'(S_AXI_AWREADY), 32'd1);
    chk("w_accept", 32'(S_AXI_WREADY), 32'd1);
    if (lat) chk("wr_accept_lat", 32'(n), 32'd1);
    @(posedge clk);
    #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
  endtask

  task automatic drive_r(input ipreq_t t, input bit lat);
    int n;
    S_AXI_ARADDR  = t.addr;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!S_AXI_ARREADY && n < 100);
    chk("ar_accept", 32'(S_AXI_ARREADY), 32'd1);
    if (lat) chk("rd_accept_lat", 32'(n), 32'd1);
    @(posedge clk);
    #1;
    S_AXI_ARVALID = 1'b0;
  endtask

  // Reference ordering: a lone request is served as is; two at once
  // go write-first unless the last served transaction was a write.
  task automatic issue(input bit dow, input bit dor,
                       input ipreq_t w, input ipreq_t r,
                       input int wdly);
    int tgt;
    bit lat;
    if (dow && dor) begin
      if (last_rd_m) begin
        ip_q.push_back(w);
        ip_q.push_back(r);
      end else begin
        ip_q.push_back(r);
        ip_q.push_back(w);
      end
    end else if (dow) begin
      ip_q.push_back(w);
      last_rd_m = 1'b0;
    end else if (dor) begin
      ip_q.push_back(r);
      last_rd_m = 1'b1;
    end
    tgt = rsp_seen + int'(dow) + int'(dor);
    lat = !(dow && dor);
    fork
      if (dow) drive_w(w, wdly, lat);
      if (dor) drive_r(r, lat);
    join
    for (int i = 0; i < 200 && rsp_seen < tgt; i++) @(negedge clk);
    if (rsp_seen < tgt) fail("resp_wait");
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin : main
    ipreq_t w, r;
    int     k, n;
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("rst_cs", 32'(Bus2IP_CS), 32'd0);
    chk("rst_rnw", 32'(Bus2IP_RNW), 32'd1);
    chk("rst_addr", Bus2IP_Addr, 32'd0);
    chk("rst_data", Bus2IP_Data, 32'd0);
    chk("rst_be", 32'(Bus2IP_BE), 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_resps", 32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
    chk("rst_fwd", 32'(Bus2IP_Resetn), 32'(rst_n));
    rst_n = 1'b1;
    @(negedge clk);
    chk("resetn_fwd", 32'(Bus2IP_Resetn), 32'd1);

    issue(1, 1, mk(0), mk(1), 0);
    issue(1, 1, mk(0), mk(1), 0);

    directed = 1'b1;
    f_dly = 1; f_err = 1'b0;
    w.rnw = 0; w.addr = 32'h08; w.data = 32'hDEADBEEF; w.be = 4'hF;
    issue(1, 0, w, mk(1), 0);
    f_dly = 0; f_rdata = 32'h12345678;
    r = mk(1);
    r.addr = 32'h0C;
    issue(0, 1, mk(0), r, 0);
    f_dly = 2; f_err = 1'b1;
    issue(1, 0, mk(0), mk(1), 0);
    directed = 1'b0;

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 2);
      if (k == 0) issue(1, 0, mk(0), mk(1), $urandom_range(0, 2));
      else if (k == 1) issue(0, 1, mk(0), mk(1), 0);
      else issue(1, 1, mk(0), mk(1), 0);
    end

`ifdef IPIF_BRIDGE_TIMEOUT_EN
    ip_silent = 1'b1;
    begin
      resp_t x;
      x.rnw = 1'b1; x.resp = 2'b10; x.data = 32'h0;
      rsp_q.push_back(x);
    end
    k = rsp_seen + 1;
    drive_r(mk(1), 1);
    last_rd_m = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (Bus2IP_CS) n++;
    end while (Bus2IP_CS && n < 40);
    chk("tmo_cs_cycles", 32'(n + 1), 32'd8);
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    late_ack = 1'b0;
    for (int i = 0; i < 100 && rsp_seen < k; i++) @(negedge clk);
    if (rsp_seen < k) fail("tmo_resp_wait");
    @(negedge clk);
    ip_silent = 1'b0;
`endif

    ip_silent = 1'b1;
    drive_w(mk(0), 0, 1);
    chk("cs_pre_rst", 32'(Bus2IP_CS), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("cs_async_rst", 32'(Bus2IP_CS), 32'd0);
    chk("bvalid_async_rst", 32'(S_AXI_BVALID), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("bvalid_in_rst", 32'(S_AXI_BVALID), 32'd0);
    end
    rst_n = 1'b1;
    last_rd_m = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_after_rst", 32'({Bus2IP_CS, S_AXI_BVALID}), 32'd0);
    end
    ip_silent = 1'b0;
    issue(1, 1, mk(0), mk(1), 0);

    if (ip_q.size() != 0) fail("ip_q_leftover");
    if (rsp_q.size() != 0) fail("rsp_q_leftover");
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
